fp_mul_arbiter: RTL and testbench
=================================

Name: fp_mul_arbiter

Overview:
- Shares one single-precision IEEE754 multiplier (ready/op1/op2/res/done interface) among NREQ independent requesters.
- Round-robin arbitration, one operation in flight at a time.
- Issues the multiplier start pulse with registered operands and waits for the multiplier's done.
- Returns the product to the winning requester with a one-cycle done pulse.
- Sits between requester FSMs (e.g. dual-issue sequencers) and a single multiplier instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 32, operand/result width (IEEE754 single).
- TIMEOUT_CYC, 255, watchdog limit in cycles while waiting for mul_done (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request level; operands must be held stable while high.
- op1_bus  in  NREQ*W  packed first operands; requester i uses bits [i*W +: W].
- op2_bus  in  NREQ*W  packed second operands, same packing.
- res  out  W  product of the last completed operation; valid when any done bit is high.
- done  out  NREQ  one-hot, one-cycle completion pulse to the granted requester.
- err  out  NREQ  one-hot, one-cycle timeout flag coincident with done; constant 0 without the optional feature.
- busy  out  1  high from grant until return to IDLE.
- grant_id  out  $clog2(NREQ)  index of current or last granted requester.
- mul_ready  out  1  start pulse to the multiplier.
- mul_op1  out  W  operand to the multiplier.
- mul_op2  out  W  operand to the multiplier.
- mul_res  in  W  multiplier result.
- mul_done  in  1  multiplier completion; may be a pulse or a held level.

Behaviour:
- Reset (rst=0, async): state=IDLE.
  - res, mul_op1, mul_op2 = 0.
  - done, err = 0. mul_ready, busy = 0.
  - grant_id = 0. RR pointer last = NREQ-1, so requester 0 has first priority.
- All outputs are registered.
- IDLE:
  - If req != 0, winner = first set bit searching last+1, last+2, ... with wrap modulo NREQ.
  - Register grant_id, last, mul_op1/mul_op2 from the winner's slices. Set busy=1 and mul_ready=1. Go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle): mul_ready high, operands stable. Next cycle mul_ready=0. Go to WAIT.
- WAIT:
  - mul_op1/mul_op2 stay held.
  - On the first cycle mul_done=1: res <= mul_res, done[grant_id] <= 1. Go to RET.
  - A mul_done already high in the ISSUE cycle is ignored; completion is counted from WAIT only.
- RET (1 cycle): done pulse visible, then cleared. Go to DRAIN.
- DRAIN:
  - Stay while mul_done=1, so a held done level cannot complete the next operation.
  - On mul_done=0, set busy=0 and go to IDLE.
  - Minimum 1 cycle, which gives requesters a cycle to drop req before re-arbitration.
- Latency: best case from req sampled to done pulse is 4 cycles plus the multiplier's cycles from mul_ready to mul_done.
- Requester rules:
  - Drop req in the cycle it sees its done bit; keep it dropped for at least 1 cycle.
  - Re-asserting req afterwards is a new request.
  - req dropped before done (abort) is not supported. The operation still completes and the done pulse is still issued.
- Fairness: a requester holding req waits at most NREQ-1 operations.
- res holds its value until the next completion.
- Reset mid-operation: immediate return to IDLE with all outputs cleared. The in-flight result is discarded and no done is issued. The shared multiplier must be reset by the same rst.
- State encoding: 3 bits. Illegal states go to IDLE on the next clock.

Optional Feature:
- Macro FP_MUL_ARB_TIMEOUT_EN.
- Enabled: a cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYC with mul_done still 0: res <= 32'h7FC00000 (quiet NaN), done[grant_id]=1 and err[grant_id]=1 for one cycle.
  - The FSM then goes to RET/DRAIN as normal.
  - mul_done arriving in the same cycle as the timeout wins: normal result, no err.
- Disabled: no counter is built, err is tied to 0, and WAIT is unbounded.

Test Plan:
- Single request: req[0]=1, op1=0x40400000, op2=0x40000000 -> one mul_ready pulse with those operands, then done=4'b0001 with res=0x40C00000; busy falls after DRAIN.
- Simultaneous req=4'b0110 after reset -> grant order is 1 then 2. Each done is one-hot and one cycle. res is 0x3F800000 for 1.0*1.0 (req1) and 0xC0800000 for -2.0*2.0 (req2).
- All four requesters hold req, re-asserting after each done -> grant_id sequence 0,1,2,3,0,1; no requester skipped or granted twice in a row.
- mul_done held high for 5 cycles -> exactly one done pulse. No new mul_ready until 1 cycle after mul_done falls.
- rst pulled low during WAIT -> all outputs 0 asynchronously. After release, a pending req[3] is serviced; no stale done appears.
- With FP_MUL_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, mul_done never asserts -> 16 cycles into WAIT, done and err fire for the grantee with res=0x7FC00000. The next request is then serviced normally.

Source files
------------

// File: rtl/fp_mul_arbiter_if.sv
// Requester and multiplier signal bundle for fp_mul_arbiter.
// The slave modport is the arbiter's view; master is the environment's.
interface fp_mul_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 32
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] op1_bus;
    logic [NREQ*W-1:0] op2_bus;
    logic [W-1:0]      res;
    logic [NREQ-1:0]   done;
    logic [NREQ-1:0]   err;
    logic              busy;
    logic [IW-1:0]     grant_id;
    logic              mul_ready;
    logic [W-1:0]      mul_op1;
    logic [W-1:0]      mul_op2;
    logic [W-1:0]      mul_res;
    logic              mul_done;

    modport slave (
        input  req, op1_bus, op2_bus, mul_res, mul_done,
        output res, done, err, busy, grant_id,
        output mul_ready, mul_op1, mul_op2
    );

    modport master (
        output req, op1_bus, op2_bus, mul_res, mul_done,
        input  res, done, err, busy, grant_id,
        input  mul_ready, mul_op1, mul_op2
    );
endinterface

// File: rtl/fp_mul_arbiter.sv
// Round-robin sharing of one FP multiplier among NREQ requesters.
// Optional WAIT watchdog enabled by defining FP_MUL_ARB_TIMEOUT_EN.
module fp_mul_arbiter #(
    parameter int NREQ        = 4,
    parameter int W           = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    fp_mul_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RET   = 3'd3,
        S_DRAIN = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [IW-1:0]   last_q, last_d;
    logic [W-1:0]    res_q, res_d;
    logic [W-1:0]    op1_q, op1_d;
    logic [W-1:0]    op2_q, op2_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [NREQ-1:0] err_q, err_d;
    logic            busy_q, busy_d;
    logic            rdy_q, rdy_d;
    logic            found;
    logic [IW-1:0]   win;
    logic [IW-1:0]   cand;
    logic            tmo;

    // First pending requester after the last grant, wrapping
    always_comb begin
        found = 1'b0;
        win   = last_q;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last_q) + k) % NREQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

`ifdef FP_MUL_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (state_q == S_WAIT) ? cnt_q + CW'(1) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign tmo = (cnt_q == CW'(TIMEOUT_CYC - 1));
`else
    // Watchdog absent: WAIT only ends on mul_done
    assign tmo = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= IW'(NREQ - 1);
            res_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            res_q   <= res_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (found) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (bus.mul_done || tmo) state_d = S_RET;
            S_RET:   state_d = S_DRAIN;
            S_DRAIN: if (!bus.mul_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        grant_d = grant_q;
        last_d  = last_q;
        res_d   = res_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        busy_d  = busy_q;
        done_d  = '0;
        err_d   = '0;
        rdy_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = win;
                    last_d  = win;
                    op1_d   = bus.op1_bus[int'(win)*W +: W];
                    op2_d   = bus.op2_bus[int'(win)*W +: W];
                    busy_d  = 1'b1;
                    rdy_d   = 1'b1;
                end
            end
            S_WAIT: begin
                // A real result beats a same-cycle timeout
                if (bus.mul_done) begin
                    res_d          = bus.mul_res;
                    done_d[grant_q] = 1'b1;
                end else if (tmo) begin
                    res_d           = W'(32'h7FC0_0000);
                    done_d[grant_q] = 1'b1;
                    err_d[grant_q]  = 1'b1;
                end
            end
            S_DRAIN: begin
                if (!bus.mul_done) busy_d = 1'b0;
            end
            S_ISSUE, S_RET: ;
            default: busy_d = 1'b0;
        endcase
    end

    assign bus.res       = res_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;
    assign bus.grant_id  = grant_q;
    assign bus.mul_ready = rdy_q;
    assign bus.mul_op1   = op1_q;
    assign bus.mul_op2   = op2_q;
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Randomized and directed checks of fp_mul_arbiter against a
// transaction-level model of round-robin grants and results.
module tb_fp_mul_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 32;
`ifdef FP_MUL_ARB_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 255;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_mul_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

    fp_mul_arbiter #(
        .NREQ(NREQ), .W(W), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    logic [W-1:0] op1 [NREQ];
    logic [W-1:0] op2 [NREQ];
    int cool [NREQ];
    int wait_ops [NREQ];
    bit rand_mode = 0;
    bit auto_re = 0;

    int m_last, m_gid, m_win;
    bit inflight, answered;
    logic [W-1:0] m_o1, m_o2, m_exp;
    int cyc = 0, ready_cyc = 0, lowcnt = 10;
    int ndone = 0, nready = 0;
    int gseq [$];
    logic [W-1:0] rseq [$];
    logic [NREQ-1:0] dseq [$];
    logic [W-1:0] last_mo1, last_mo2, last_res;
    logic [NREQ-1:0] last_dvec, last_err;

    int cd = 0, hcnt = 0, hnext = 1;
    int force_L = 0, force_H = 0;
    bit mul_never = 0;
    logic [W-1:0] mq1, mq2;

    // Behavioural multiplier: exact products for known pairs, else a hash
    function automatic logic [W-1:0] fmul(logic [W-1:0] a, logic [W-1:0] b);
        if (a == 32'h40400000 && b == 32'h40000000) return 32'h40C00000;
        if (a == 32'h3F800000 && b == 32'h3F800000) return 32'h3F800000;
        if (a == 32'hC0000000 && b == 32'h40000000) return 32'hC0800000;
        return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A0001;
    endfunction

    function automatic int pick(logic [NREQ-1:0] r, int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic pack_ops();
        for (int i = 0; i < NREQ; i++) begin
            bus.op1_bus[i*W +: W] = op1[i];
            bus.op2_bus[i*W +: W] = op2[i];
        end
    endtask

    task automatic clear_model();
        inflight = 0;
        m_last = NREQ - 1;
        m_gid = 0;
        cd = 0;
        hcnt = 0;
        lowcnt = 10;
        bus.mul_done = 1'b0;
        bus.mul_res = '0;
        for (int i = 0; i < NREQ; i++) begin
            cool[i] = 0;
            wait_ops[i] = 0;
        end
        gseq.delete();
        rseq.delete();
        dseq.delete();
    endtask

    // One cycle: compare DUT to model, then advance multiplier and requesters
    task automatic step();
        bit tmo_case;
        cyc++;
        lowcnt = bus.mul_done ? 0 : lowcnt + 1;
        if (bus.mul_ready) begin
            nready++;
            chk("ready_while_busy", inflight, 0);
            chk("ready_gap", lowcnt >= 2, 1);
            m_win = pick(bus.req, m_last);
            chk("winner", bus.grant_id, m_win);
            if (m_win >= 0) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (i != m_win && bus.req[i]) begin
                        wait_ops[i]++;
                        chk("fairness", wait_ops[i] <= NREQ - 1, 1);
                    end
                end
                wait_ops[m_win] = 0;
                m_last = m_win;
                m_gid = m_win;
                m_o1 = op1[m_win];
                m_o2 = op2[m_win];
                m_exp = fmul(m_o1, m_o2);
                gseq.push_back(m_win);
            end
            inflight = 1;
            answered = 0;
            ready_cyc = cyc;
            last_mo1 = bus.mul_op1;
            last_mo2 = bus.mul_op2;
        end
        chk("grant_id", bus.grant_id, m_gid);
        if (inflight) begin
            chk("mul_op1", bus.mul_op1, m_o1);
            chk("mul_op2", bus.mul_op2, m_o2);
            chk("busy", bus.busy, 1);
            if (cyc - ready_cyc > 300) begin
                chk("op_watchdog", 0, 1);
                inflight = 0;
            end
        end
        if (bus.done != '0) begin
            chk("done_inflight", inflight, 1);
            chk("done_vec", bus.done, 64'(1) << m_gid);
            tmo_case = 0;
`ifdef FP_MUL_ARB_TIMEOUT_EN
            tmo_case = !answered;
`endif
            if (tmo_case) begin
                chk("tmo_res", bus.res, 32'h7FC00000);
                chk("tmo_err", bus.err, bus.done);
                chk("tmo_latency", cyc - ready_cyc, TMO + 1);
            end else begin
                chk("res", bus.res, m_exp);
                chk("err_clear", bus.err, 0);
            end
            ndone++;
            last_dvec = bus.done;
            last_res = bus.res;
            last_err = bus.err;
            rseq.push_back(bus.res);
            dseq.push_back(bus.done);
            inflight = 0;
        end else begin
            chk("err_idle", bus.err, 0);
        end

        if (hcnt > 0) begin
            hcnt--;
            if (hcnt == 0) bus.mul_done = 1'b0;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                bus.mul_done = 1'b1;
                bus.mul_res = fmul(mq1, mq2);
                hcnt = hnext;
                answered = 1;
            end
        end
        if (bus.mul_ready) begin
            mq1 = bus.mul_op1;
            mq2 = bus.mul_op2;
            cd = mul_never ? 0 :
                 (force_L > 0 ? force_L : int'($urandom_range(1, 4)));
            hnext = force_H > 0 ? force_H : int'($urandom_range(1, 3));
        end

        for (int i = 0; i < NREQ; i++) begin
            if (bus.done[i]) begin
                bus.req[i] = 1'b0;
                cool[i] = rand_mode ? int'($urandom_range(1, 3)) : 1;
            end else if (!bus.req[i]) begin
                if (cool[i] > 0) cool[i]--;
                else if (auto_re) bus.req[i] = 1'b1;
                else if (rand_mode && ($urandom % 4 == 0)) begin
                    op1[i] = $urandom;
                    op2[i] = $urandom;
                    bus.req[i] = 1'b1;
                end
            end
        end
        pack_ops();
    endtask

    task automatic cycles(input int n);
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            step();
        end
    endtask

    task automatic wait_done(input int target, input int bound,
                             input string nm);
        for (int t = 0; t < bound && ndone < target; t++) begin
            @(negedge clk);
            step();
        end
        chk(nm, ndone >= target, 1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.req = '0;
        clear_model();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int n0, r0;
        bus.req = '0;
        for (int i = 0; i < NREQ; i++) begin
            op1[i] = '0;
            op2[i] = '0;
        end
        pack_ops();

        // Reset state and single request
        do_reset();
        chk("rst_res", bus.res, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ready", bus.mul_ready, 0);
        chk("rst_gid", bus.grant_id, 0);
        chk("rst_op1", bus.mul_op1, 0);
        chk("rst_op2", bus.mul_op2, 0);
        op1[0] = 32'h40400000;
        op2[0] = 32'h40000000;
        pack_ops();
        bus.req[0] = 1'b1;
        n0 = ndone;
        r0 = nready;
        wait_done(n0 + 1, 50, "t1_complete");
        chk("t1_mulop1", last_mo1, 32'h40400000);
        chk("t1_mulop2", last_mo2, 32'h40000000);
        chk("t1_done", last_dvec, 4'b0001);
        chk("t1_res", last_res, 32'h40C00000);
        for (int t = 0; t < 10 && bus.busy; t++) cycles(1);
        chk("t1_busy_fall", bus.busy, 0);
        chk("t1_ready_pulses", nready - r0, 1);
        chk("t1_res_held", bus.res, 32'h40C00000);

        // Simultaneous requesters 1 and 2
        do_reset();
        op1[1] = 32'h3F800000; op2[1] = 32'h3F800000;
        op1[2] = 32'hC0000000; op2[2] = 32'h40000000;
        pack_ops();
        bus.req = 4'b0110;
        wait_done(ndone + 2, 80, "t2_complete");
        if (gseq.size() >= 2 && rseq.size() >= 2) begin
            chk("t2_grant0", gseq[0], 1);
            chk("t2_grant1", gseq[1], 2);
            chk("t2_res0", rseq[0], 32'h3F800000);
            chk("t2_res1", rseq[1], 32'hC0800000);
            chk("t2_done0", dseq[0], 4'b0010);
            chk("t2_done1", dseq[1], 4'b0100);
        end else chk("t2_count", gseq.size(), 2);

        // All four requesters re-asserting
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            op1[i] = $urandom;
            op2[i] = $urandom;
        end
        pack_ops();
        bus.req = 4'b1111;
        auto_re = 1;
        for (int t = 0; t < 200 && gseq.size() < 6; t++) cycles(1);
        auto_re = 0;
        chk("t3_count", gseq.size() >= 6, 1);
        if (gseq.size() >= 6) begin
            chk("t3_g0", gseq[0], 0);
            chk("t3_g1", gseq[1], 1);
            chk("t3_g2", gseq[2], 2);
            chk("t3_g3", gseq[3], 3);
            chk("t3_g4", gseq[4], 0);
            chk("t3_g5", gseq[5], 1);
        end

        // Held mul_done level
        do_reset();
        force_L = 2;
        force_H = 5;
        op1[0] = $urandom; op2[0] = $urandom;
        op1[1] = $urandom; op2[1] = $urandom;
        pack_ops();
        bus.req = 4'b0011;
        n0 = ndone;
        r0 = nready;
        wait_done(n0 + 2, 100, "t4_complete");
        cycles(10);
        chk("t4_dones", ndone - n0, 2);
        chk("t4_readies", nready - r0, 2);
        force_L = 0;
        force_H = 0;

        // Reset during WAIT
        do_reset();
        force_L = 20;
        op1[3] = 32'h40400000;
        op2[3] = 32'h40000000;
        pack_ops();
        bus.req[3] = 1'b1;
        for (int t = 0; t < 20 && !inflight; t++) cycles(1);
        cycles(3);
        #2 rst = 1'b0;
        #1;
        chk("t5_busy", bus.busy, 0);
        chk("t5_ready", bus.mul_ready, 0);
        chk("t5_done", bus.done, 0);
        chk("t5_res", bus.res, 0);
        chk("t5_op1", bus.mul_op1, 0);
        chk("t5_gid", bus.grant_id, 0);
        clear_model();
        force_L = 0;
        @(negedge clk);
        rst = 1'b1;
        n0 = ndone;
        wait_done(n0 + 1, 50, "t5_complete");
        chk("t5_after_done", last_dvec, 4'b1000);
        chk("t5_after_res", last_res, 32'h40C00000);

`ifdef FP_MUL_ARB_TIMEOUT_EN
        do_reset();
        mul_never = 1;
        op1[0] = $urandom; op2[0] = $urandom;
        pack_ops();
        bus.req[0] = 1'b1;
        wait_done(ndone + 1, 60, "t6_complete");
        chk("t6_err", last_err, 4'b0001);
        chk("t6_res", last_res, 32'h7FC00000);
        mul_never = 0;
        cycles(3);
        op1[1] = 32'h3F800000; op2[1] = 32'h3F800000;
        pack_ops();
        bus.req[1] = 1'b1;
        wait_done(ndone + 1, 60, "t6_next");
        chk("t6_next_err", last_err, 0);
        chk("t6_next_res", last_res, 32'h3F800000);
`endif

        // Randomized traffic
        do_reset();
        rand_mode = 1;
        n0 = ndone;
        cycles(3000);
        rand_mode = 0;
        chk("rand_progress", ndone - n0 > 100, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got running expected finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
